bht_resolve_queue: RTL and testbench
====================================

BHT_RESOLVE_QUEUE -- requirements
Module: bht_resolve_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, number of in-flight prediction entries (power of two, 2..32).
REQ-002 The block SHALL have parameter IDX_W, default `BHT_IDX_WIDTH, predictor index width.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low: clk_i  input  1  rising-edge clock; rst_ni  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have ports alloc_valid_i  input  1, alloc_ready_o  output  1: fetch-side allocation handshake.
REQ-005 The block SHALL have ports alloc_idx_i  input  IDX_W, alloc_domain_i  input  domain_t, alloc_pred_i  input  1, alloc_targ_i  input  32: the predictor index, domain, prediction and target of the allocated entry.
REQ-006 The block SHALL have port alloc_tag_o  output  log2(DEPTH): slot index granted to the current allocation.
REQ-007 The block SHALL have ports resolve_valid_i  input  1, resolve_tag_i  input  log2(DEPTH), resolve_taken_i  input  1, resolve_targ_i  input  32: execute-side resolution.
REQ-008 The block SHALL have port flush_i  input  1: squash of all in-flight entries.
REQ-009 The block SHALL have ports upd_valid_o  output  1, upd_ready_i  input  1, upd_idx_o  output  IDX_W, upd_domain_o  output  domain_t, upd_taken_o  output  1, upd_targ_o  output  32: the update stream feeding the predictor's br_result/update_en/target/domain inputs.
REQ-010 The block SHALL have ports mispredict_o  output  1, mispredict_tag_o  output  log2(DEPTH), count_o  output  log2(DEPTH)+1.

Function
REQ-011 Each entry SHALL be in exactly one state: FREE, PENDING, RESOLVED; entries SHALL be allocated at the tail and retired at the head, both pointers wrapping modulo DEPTH.
REQ-012 alloc_ready_o SHALL equal (count_o < DEPTH) and SHALL NOT depend on same-cycle retirement; alloc_tag_o SHALL equal the tail pointer.
REQ-013 An allocation occurs when alloc_valid_i and alloc_ready_o are both 1 and flush_i is 0; the tail entry SHALL become PENDING with the captured fields at the next edge.
REQ-014 A resolution on a PENDING tag SHALL store resolve_taken_i/resolve_targ_i and move the entry to RESOLVED; a resolution on a FREE or RESOLVED tag SHALL be ignored.
REQ-015 mispredict_o SHALL pulse for one cycle, registered one cycle after an accepted resolution, when taken != stored pred, or taken=1 and targ != stored targ; mispredict_tag_o SHALL carry the resolved tag and hold 0 otherwise.
REQ-016 upd_valid_o SHALL be 1 iff the head entry is RESOLVED and its domain is PRIV or USER; upd_* fields SHALL come from the head entry and remain stable while upd_valid_o=1 and upd_ready_i=0.
REQ-017 The head SHALL retire when upd_valid_o and upd_ready_i are 1, or immediately (no update issued) when the head is RESOLVED with domain INIT.
REQ-018 At most one allocation and one retirement SHALL occur per cycle; simultaneous allocation and retirement SHALL leave count_o unchanged.
REQ-019 A resolution and an allocation to the same slot in one cycle cannot both be legal; the resolution SHALL be ignored (slot is FREE).
REQ-020 flush_i SHALL have priority over allocation, resolution and retirement: at the next edge all entries become FREE, pointers and count_o go to 0, and no update or mispredict pulse is issued for squashed entries; upd_valid_o may drop without handshake on flush.
REQ-021 count_o SHALL equal the number of non-FREE entries and never exceed DEPTH.

Reset
REQ-022 On rst_ni low, asynchronously: all entries FREE, pointers 0, count_o 0, alloc_ready_o 1, upd_valid_o 0, mispredict_o 0, mispredict_tag_o 0; entry payload registers need not reset.
REQ-023 Reset asserted mid-operation SHALL discard all entries with no update issued; first allocation is accepted on the first edge after rst_ni rises.

Structure
REQ-024 Shared package bht_pkg SHALL hold the entry-state enum and the update struct (idx, domain, taken, targ); domain_t and `BHT_IDX_WIDTH remain in common_defines.svh.
REQ-025 The block SHALL be a single module with no sub-modules; entry storage is a flat register array indexed by tag.

Verification
REQ-026 Reset, allocate idx=5 USER pred=1 targ=0x100, resolve tag 0 taken=1 targ=0x100 -> no mispredict, upd_valid_o=1 with idx=5 USER taken=1 targ=0x100.
REQ-027 Allocate tags 0,1,2; resolve 2 then 0 then 1 with upd_ready_i=1 -> updates issued in order 0,1,2; update for 0 only after tag 0 resolves.
REQ-028 Allocate 8 (DEPTH=8) -> alloc_ready_o=0, count_o=8; retire head while alloc_valid_i=1 -> no allocation that cycle, count_o=7 next cycle.
REQ-029 Resolve tag with pred=1 targ=0x200 as taken=1 targ=0x204 -> mispredict_o=1 for one cycle next cycle, mispredict_tag_o=tag; taken=0 with pred=0 -> no pulse.
REQ-030 Hold upd_ready_i=0 five cycles with head RESOLVED -> upd_* stable; assert flush_i -> upd_valid_o=0, count_o=0 next cycle, wrap tail past 7 afterwards works.
REQ-031 Allocate with domain INIT, resolve it -> head retires without upd_valid_o; resolve of FREE tag 3 -> no state change.

Source files
------------

// File: rtl/bht_pkg.sv
// Shared types for the branch-history resolve queue: per-entry state and the
// update record handed to the predictor.
`include "common_defines.svh"

package bht_pkg;

    typedef enum logic [1:0] {
        FREE     = 2'd0,
        PENDING  = 2'd1,
        RESOLVED = 2'd2
    } entry_state_e;

    typedef struct packed {
        logic [`BHT_IDX_WIDTH-1:0] idx;
        domain_t                   domain;
        logic                      taken;
        logic [31:0]               targ;
    } bht_upd_t;

    // Only PRIV and USER branches train the predictor; anything else retires silently.
    function automatic logic is_update_domain(input domain_t d);
        return (d == PRIV) || (d == USER);
    endfunction

endpackage

// File: rtl/bht_resolve_queue_if.sv
// Signal bundle around the resolve queue. Handshakes (alloc, upd) are
// valid/ready: a transfer happens on a rising edge where both are 1; the
// source holds its payload stable while valid=1 and ready=0.
`include "common_defines.svh"

interface bht_resolve_queue_if #(
    parameter int IDX_W = `BHT_IDX_WIDTH,
    parameter int TAG_W = 3
);
    logic             alloc_valid_i;
    logic             alloc_ready_o;
    logic [IDX_W-1:0] alloc_idx_i;
    domain_t          alloc_domain_i;
    logic             alloc_pred_i;
    logic [31:0]      alloc_targ_i;
    logic [TAG_W-1:0] alloc_tag_o;

    logic             resolve_valid_i;
    logic [TAG_W-1:0] resolve_tag_i;
    logic             resolve_taken_i;
    logic [31:0]      resolve_targ_i;

    logic             flush_i;

    logic             upd_valid_o;
    logic             upd_ready_i;
    logic [IDX_W-1:0] upd_idx_o;
    domain_t          upd_domain_o;
    logic             upd_taken_o;
    logic [31:0]      upd_targ_o;

    logic             mispredict_o;
    logic [TAG_W-1:0] mispredict_tag_o;
    logic [TAG_W:0]   count_o;

    // Fetch/execute/predictor side: drives requests, observes the queue.
    modport master (
        output alloc_valid_i, alloc_idx_i, alloc_domain_i, alloc_pred_i, alloc_targ_i,
        output resolve_valid_i, resolve_tag_i, resolve_taken_i, resolve_targ_i,
        output flush_i, upd_ready_i,
        input  alloc_ready_o, alloc_tag_o, upd_valid_o, upd_idx_o, upd_domain_o,
        input  upd_taken_o, upd_targ_o, mispredict_o, mispredict_tag_o, count_o
    );

    // Queue side.
    modport slave (
        input  alloc_valid_i, alloc_idx_i, alloc_domain_i, alloc_pred_i, alloc_targ_i,
        input  resolve_valid_i, resolve_tag_i, resolve_taken_i, resolve_targ_i,
        input  flush_i, upd_ready_i,
        output alloc_ready_o, alloc_tag_o, upd_valid_o, upd_idx_o, upd_domain_o,
        output upd_taken_o, upd_targ_o, mispredict_o, mispredict_tag_o, count_o
    );

endinterface

// File: rtl/common_defines.svh
// Project-wide defines shared by the branch predictor blocks.
`ifndef COMMON_DEFINES_SVH
`define COMMON_DEFINES_SVH

`define BHT_IDX_WIDTH 10

// Privilege domain a branch was fetched in. INIT-domain branches are never
// used to train the predictor.
typedef enum logic [1:0] {
    INIT = 2'd0,
    PRIV = 2'd1,
    USER = 2'd2
} domain_t;

`endif

// File: rtl/bht_resolve_queue.sv
// In-order queue of in-flight branch predictions. Entries are allocated at
// fetch, resolved out of order at execute, and retired in order at the head,
// where resolved PRIV/USER entries become predictor updates.
`include "common_defines.svh"

module bht_resolve_queue
    import bht_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int IDX_W = `BHT_IDX_WIDTH,
    localparam int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic             alloc_valid_i,
    output logic             alloc_ready_o,
    input  logic [IDX_W-1:0] alloc_idx_i,
    input  domain_t          alloc_domain_i,
    input  logic             alloc_pred_i,
    input  logic [31:0]      alloc_targ_i,
    output logic [TAG_W-1:0] alloc_tag_o,

    input  logic             resolve_valid_i,
    input  logic [TAG_W-1:0] resolve_tag_i,
    input  logic             resolve_taken_i,
    input  logic [31:0]      resolve_targ_i,

    input  logic             flush_i,

    output logic             upd_valid_o,
    input  logic             upd_ready_i,
    output logic [IDX_W-1:0] upd_idx_o,
    output domain_t          upd_domain_o,
    output logic             upd_taken_o,
    output logic [31:0]      upd_targ_o,

    output logic             mispredict_o,
    output logic [TAG_W-1:0] mispredict_tag_o,
    output logic [TAG_W:0]   count_o
);

    localparam logic [TAG_W:0] FULL_CNT = (TAG_W + 1)'(DEPTH);

    // Control state.
    entry_state_e     state_q [DEPTH];
    entry_state_e     state_d [DEPTH];
    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;
    logic             mis_q, mis_d;
    logic [TAG_W-1:0] mis_tag_q, mis_tag_d;

    // Payload. The target field holds the predicted target until resolution,
    // then the resolved target that is forwarded to the predictor.
    logic [IDX_W-1:0] idx_q   [DEPTH];
    domain_t          dom_q   [DEPTH];
    logic             pred_q  [DEPTH];
    logic             taken_q [DEPTH];
    logic [31:0]      targ_q  [DEPTH];

    logic alloc_fire;
    logic res_hit;
    logic res_mis;
    logic head_resolved;
    logic head_upd_dom;
    logic retire;

    // Handshake decode; flush suppresses every state-changing event.
    always_comb begin
        alloc_ready_o = (count_q < FULL_CNT);
        alloc_fire    = !flush_i && alloc_valid_i && alloc_ready_o;
        res_hit       = !flush_i && resolve_valid_i && (state_q[resolve_tag_i] == PENDING);
        res_mis       = res_hit &&
                        ((resolve_taken_i != pred_q[resolve_tag_i]) ||
                         (resolve_taken_i && (resolve_targ_i != targ_q[resolve_tag_i])));
        head_resolved = (state_q[head_q] == RESOLVED);
        head_upd_dom  = is_update_domain(dom_q[head_q]);
        upd_valid_o   = head_resolved && head_upd_dom;
        retire        = !flush_i && head_resolved && (!head_upd_dom || upd_ready_i);
    end

    // Next-state for entry states, pointers, count and the mispredict pulse.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            state_d[i] = state_q[i];
        end
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        mis_d     = res_mis;
        mis_tag_d = res_mis ? resolve_tag_i : '0;

        if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_d[i] = FREE;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (alloc_fire) begin
                state_d[tail_q] = PENDING;
                tail_d          = tail_q + 1'b1;
            end
            // A resolve can never target the freshly allocated slot: it was FREE.
            if (res_hit) begin
                state_d[resolve_tag_i] = RESOLVED;
            end
            if (retire) begin
                state_d[head_q] = FREE;
                head_d          = head_q + 1'b1;
            end
            case ({alloc_fire, retire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= FREE;
            end
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            mis_q     <= 1'b0;
            mis_tag_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= state_d[i];
            end
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            mis_q     <= mis_d;
            mis_tag_q <= mis_tag_d;
        end
    end

    // Payload capture on allocation and resolution; contents of FREE slots are don't-care.
    always_ff @(posedge clk_i) begin
        if (alloc_fire) begin
            idx_q[tail_q]  <= alloc_idx_i;
            dom_q[tail_q]  <= alloc_domain_i;
            pred_q[tail_q] <= alloc_pred_i;
            targ_q[tail_q] <= alloc_targ_i;
        end
        if (res_hit) begin
            taken_q[resolve_tag_i] <= resolve_taken_i;
            targ_q[resolve_tag_i]  <= resolve_targ_i;
        end
    end

    // Output assignments.
    always_comb begin
        alloc_tag_o      = tail_q;
        upd_idx_o        = idx_q[head_q];
        upd_domain_o     = dom_q[head_q];
        upd_taken_o      = taken_q[head_q];
        upd_targ_o       = targ_q[head_q];
        mispredict_o     = mis_q;
        mispredict_tag_o = mis_tag_q;
        count_o          = count_q;
    end

endmodule

// File: tb/tb_bht_resolve_queue.sv
// Directed bench for bht_resolve_queue (DEPTH=8): allocation/resolution
// ordering, mispredict pulses, full queue, back-pressure, flush, INIT-domain
// silent retirement, pointer wrap and asynchronous reset.
`include "common_defines.svh"

module tb_bht_resolve_queue;
    import bht_pkg::*;

    localparam int DEPTH = 8;
    localparam int IDX_W = `BHT_IDX_WIDTH;
    localparam int TAG_W = 3;

    // Clock and reset.
    logic clk_i = 1'b0;
    logic rst_ni;
    always #5 clk_i = ~clk_i;

    bht_resolve_queue_if #(.IDX_W(IDX_W), .TAG_W(TAG_W)) bus ();

    bht_resolve_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .alloc_valid_i    (bus.alloc_valid_i),
        .alloc_ready_o    (bus.alloc_ready_o),
        .alloc_idx_i      (bus.alloc_idx_i),
        .alloc_domain_i   (bus.alloc_domain_i),
        .alloc_pred_i     (bus.alloc_pred_i),
        .alloc_targ_i     (bus.alloc_targ_i),
        .alloc_tag_o      (bus.alloc_tag_o),
        .resolve_valid_i  (bus.resolve_valid_i),
        .resolve_tag_i    (bus.resolve_tag_i),
        .resolve_taken_i  (bus.resolve_taken_i),
        .resolve_targ_i   (bus.resolve_targ_i),
        .flush_i          (bus.flush_i),
        .upd_valid_o      (bus.upd_valid_o),
        .upd_ready_i      (bus.upd_ready_i),
        .upd_idx_o        (bus.upd_idx_o),
        .upd_domain_o     (bus.upd_domain_o),
        .upd_taken_o      (bus.upd_taken_o),
        .upd_targ_o       (bus.upd_targ_o),
        .mispredict_o     (bus.mispredict_o),
        .mispredict_tag_o (bus.mispredict_tag_o),
        .count_o          (bus.count_o)
    );

    int n_compared   = 0;
    int n_mismatched = 0;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_upd(input string tag, input bht_upd_t e);
        check({tag, "_valid"}, 64'(bus.upd_valid_o), 64'(1));
        check({tag, "_idx"},   64'(bus.upd_idx_o),   64'(e.idx));
        check({tag, "_dom"},   64'(bus.upd_domain_o), 64'(e.domain));
        check({tag, "_taken"}, 64'(bus.upd_taken_o), 64'(e.taken));
        check({tag, "_targ"},  64'(bus.upd_targ_o),  64'(e.targ));
    endtask

    // Driver tasks.
    task automatic set_alloc(input logic v, input logic [IDX_W-1:0] idx, input domain_t d,
                             input logic p, input logic [31:0] t);
        bus.alloc_valid_i  = v;
        bus.alloc_idx_i    = idx;
        bus.alloc_domain_i = d;
        bus.alloc_pred_i   = p;
        bus.alloc_targ_i   = t;
    endtask

    task automatic set_resolve(input logic v, input logic [TAG_W-1:0] tag, input logic tk,
                               input logic [31:0] t);
        bus.resolve_valid_i = v;
        bus.resolve_tag_i   = tag;
        bus.resolve_taken_i = tk;
        bus.resolve_targ_i  = t;
    endtask

    bht_upd_t exp_upd;

    initial begin
        rst_ni = 1'b0;
        set_alloc(1'b0, '0, INIT, 1'b0, 32'h0);
        set_resolve(1'b0, '0, 1'b0, 32'h0);
        bus.flush_i     = 1'b0;
        bus.upd_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;

        // Reset state.
        check("rst_count", 64'(bus.count_o), 64'(0));
        check("rst_ready", 64'(bus.alloc_ready_o), 64'(1));
        check("rst_upd_valid", 64'(bus.upd_valid_o), 64'(0));
        check("rst_mis", 64'(bus.mispredict_o), 64'(0));
        check("rst_mis_tag", 64'(bus.mispredict_tag_o), 64'(0));
        check("rst_tag", 64'(bus.alloc_tag_o), 64'(0));
        rst_ni = 1'b1;

        // Basic allocate/resolve/update.
        set_alloc(1'b1, 10'd5, USER, 1'b1, 32'h100);
        tick();
        set_alloc(1'b0, '0, INIT, 1'b0, 32'h0);
        check("basic_count", 64'(bus.count_o), 64'(1));
        check("basic_tag", 64'(bus.alloc_tag_o), 64'(1));
        check("basic_pending_no_upd", 64'(bus.upd_valid_o), 64'(0));
        set_resolve(1'b1, 3'd0, 1'b1, 32'h100);
        tick();
        set_resolve(1'b0, '0, 1'b0, 32'h0);
        check("basic_no_mis", 64'(bus.mispredict_o), 64'(0));
        exp_upd = '{idx: 10'd5, domain: USER, taken: 1'b1, targ: 32'h100};
        check_upd("basic_upd", exp_upd);
        bus.upd_ready_i = 1'b1;
        tick();
        bus.upd_ready_i = 1'b0;
        check("basic_retired_count", 64'(bus.count_o), 64'(0));
        check("basic_retired_upd", 64'(bus.upd_valid_o), 64'(0));

        // Target mispredict on tag 1.
        set_alloc(1'b1, 10'd7, PRIV, 1'b1, 32'h200);
        tick();
        set_alloc(1'b0, '0, INIT, 1'b0, 32'h0);
        set_resolve(1'b1, 3'd1, 1'b1, 32'h204);
        tick();
        set_resolve(1'b0, '0, 1'b0, 32'h0);
        check("mis_pulse", 64'(bus.mispredict_o), 64'(1));
        check("mis_tag", 64'(bus.mispredict_tag_o), 64'(1));
        tick();
        check("mis_pulse_end", 64'(bus.mispredict_o), 64'(0));
        check("mis_tag_end", 64'(bus.mispredict_tag_o), 64'(0));
        exp_upd = '{idx: 10'd7, domain: PRIV, taken: 1'b1, targ: 32'h204};
        check_upd("mis_upd", exp_upd);
        bus.upd_ready_i = 1'b1;
        tick();
        bus.upd_ready_i = 1'b0;

        // Correct not-taken prediction on tag 2: no pulse.
        set_alloc(1'b1, 10'd9, USER, 1'b0, 32'h300);
        tick();
        set_alloc(1'b0, '0, INIT, 1'b0, 32'h0);
        set_resolve(1'b1, 3'd2, 1'b0, 32'h999);
        tick();
        set_resolve(1'b0, '0, 1'b0, 32'h0);
        check("nt_no_mis", 64'(bus.mispredict_o), 64'(0));
        check("nt_upd_taken", 64'(bus.upd_taken_o), 64'(0));
        bus.upd_ready_i = 1'b1;
        tick();
        check("nt_retired", 64'(bus.count_o), 64'(0));

        // Out-of-order resolution of tags 3,4,5 with upd_ready held high.
        for (int i = 0; i < 3; i++) begin
            set_alloc(1'b1, IDX_W'(10 + i), USER, 1'b0, 32'h0);
            check("ooo_alloc_tag", 64'(bus.alloc_tag_o), 64'(3 + i));
            tick();
        end
        set_alloc(1'b0, '0, INIT, 1'b0, 32'h0);
        check("ooo_count", 64'(bus.count_o), 64'(3));
        set_resolve(1'b1, 3'd5, 1'b1, 32'h50);
        tick();
        check("ooo_tail_first_no_upd", 64'(bus.upd_valid_o), 64'(0));
        check("ooo_tail_first_count", 64'(bus.count_o), 64'(3));
        check("ooo_mis5", 64'(bus.mispredict_o), 64'(1));
        check("ooo_mis5_tag", 64'(bus.mispredict_tag_o), 64'(5));
        set_resolve(1'b1, 3'd3, 1'b0, 32'h30);
        tick();
        exp_upd = '{idx: 10'd10, domain: USER, taken: 1'b0, targ: 32'h30};
        check_upd("ooo_upd0", exp_upd);
        check("ooo_mis3", 64'(bus.mispredict_o), 64'(0));
        set_resolve(1'b1, 3'd4, 1'b1, 32'h40);
        tick();
        set_resolve(1'b0, '0, 1'b0, 32'h0);
        check("ooo_count2", 64'(bus.count_o), 64'(2));
        exp_upd = '{idx: 10'd11, domain: USER, taken: 1'b1, targ: 32'h40};
        check_upd("ooo_upd1", exp_upd);
        tick();
        check("ooo_count1", 64'(bus.count_o), 64'(1));
        exp_upd = '{idx: 10'd12, domain: USER, taken: 1'b1, targ: 32'h50};
        check_upd("ooo_upd2", exp_upd);
        tick();
        check("ooo_drained", 64'(bus.count_o), 64'(0));
        check("ooo_drained_upd", 64'(bus.upd_valid_o), 64'(0));
        bus.upd_ready_i = 1'b0;

        // Fill all eight slots starting at tag 6 (tail wraps).
        for (int i = 0; i < DEPTH; i++) begin
            set_alloc(1'b1, IDX_W'(20 + i), USER, 1'b1, 32'h66);
            check("full_alloc_tag", 64'(bus.alloc_tag_o), 64'((6 + i) % DEPTH));
            tick();
        end
        set_alloc(1'b0, '0, INIT, 1'b0, 32'h0);
        check("full_count", 64'(bus.count_o), 64'(8));
        check("full_ready", 64'(bus.alloc_ready_o), 64'(0));
        check("full_tag", 64'(bus.alloc_tag_o), 64'(6));
        set_resolve(1'b1, 3'd6, 1'b1, 32'h66);
        tick();
        set_resolve(1'b0, '0, 1'b0, 32'h0);
        check("full_no_mis", 64'(bus.mispredict_o), 64'(0));
        exp_upd = '{idx: 10'd20, domain: USER, taken: 1'b1, targ: 32'h66};
        check_upd("full_upd", exp_upd);
        // Retire while an allocation is offered: full queue must refuse it.
        set_alloc(1'b1, 10'd50, USER, 1'b0, 32'h0);
        bus.upd_ready_i = 1'b1;
        tick();
        set_alloc(1'b0, '0, INIT, 1'b0, 32'h0);
        bus.upd_ready_i = 1'b0;
        check("full_retire_count", 64'(bus.count_o), 64'(7));
        check("full_retire_tag", 64'(bus.alloc_tag_o), 64'(6));
        check("full_retire_ready", 64'(bus.alloc_ready_o), 64'(1));

        // Resolve of the now-FREE slot 6 is ignored.
        set_resolve(1'b1, 3'd6, 1'b0, 32'h0);
        tick();
        check("free_res_count", 64'(bus.count_o), 64'(7));
        check("free_res_upd", 64'(bus.upd_valid_o), 64'(0));
        check("free_res_mis", 64'(bus.mispredict_o), 64'(0));

        // Head resolved under back-pressure: outputs hold for five cycles.
        set_resolve(1'b1, 3'd7, 1'b1, 32'h77);
        tick();
        set_resolve(1'b0, '0, 1'b0, 32'h0);
        check("bp_mis", 64'(bus.mispredict_o), 64'(1));
        check("bp_mis_tag", 64'(bus.mispredict_tag_o), 64'(7));
        exp_upd = '{idx: 10'd21, domain: USER, taken: 1'b1, targ: 32'h77};
        for (int i = 0; i < 5; i++) begin
            check_upd("bp_hold", exp_upd);
            check("bp_count", 64'(bus.count_o), 64'(7));
            tick();
        end

        // Flush beats a concurrent allocation and a mispredicting resolution.
        bus.flush_i = 1'b1;
        set_alloc(1'b1, 10'd60, USER, 1'b1, 32'h0);
        set_resolve(1'b1, 3'd0, 1'b0, 32'h0);
        tick();
        bus.flush_i = 1'b0;
        set_alloc(1'b0, '0, INIT, 1'b0, 32'h0);
        set_resolve(1'b0, '0, 1'b0, 32'h0);
        check("flush_count", 64'(bus.count_o), 64'(0));
        check("flush_upd", 64'(bus.upd_valid_o), 64'(0));
        check("flush_mis", 64'(bus.mispredict_o), 64'(0));
        check("flush_tag", 64'(bus.alloc_tag_o), 64'(0));
        check("flush_ready", 64'(bus.alloc_ready_o), 64'(1));
        tick();
        check("flush_quiet_upd", 64'(bus.upd_valid_o), 64'(0));

        // INIT-domain entries retire silently; then wrap the tail past 7.
        for (int i = 0; i < DEPTH; i++) begin
            set_alloc(1'b1, IDX_W'(30 + i), INIT, 1'b1, 32'h0);
            tick();
        end
        set_alloc(1'b0, '0, INIT, 1'b0, 32'h0);
        check("init_full_count", 64'(bus.count_o), 64'(8));
        check("init_full_tag", 64'(bus.alloc_tag_o), 64'(0));
        set_resolve(1'b1, 3'd0, 1'b1, 32'h0);
        tick();
        set_resolve(1'b0, '0, 1'b0, 32'h0);
        check("init_no_mis", 64'(bus.mispredict_o), 64'(0));
        check("init_no_upd", 64'(bus.upd_valid_o), 64'(0));
        check("init_count_before", 64'(bus.count_o), 64'(8));
        tick();
        check("init_retired_count", 64'(bus.count_o), 64'(7));
        check("init_retired_no_upd", 64'(bus.upd_valid_o), 64'(0));
        set_alloc(1'b1, 10'd99, USER, 1'b0, 32'h0);
        check("wrap_tag_before", 64'(bus.alloc_tag_o), 64'(0));
        tick();
        set_alloc(1'b0, '0, INIT, 1'b0, 32'h0);
        check("wrap_count", 64'(bus.count_o), 64'(8));
        check("wrap_tag_after", 64'(bus.alloc_tag_o), 64'(1));

        // Asynchronous reset in mid-cycle discards everything.
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_count", 64'(bus.count_o), 64'(0));
        check("arst_ready", 64'(bus.alloc_ready_o), 64'(1));
        check("arst_upd", 64'(bus.upd_valid_o), 64'(0));
        check("arst_tag", 64'(bus.alloc_tag_o), 64'(0));
        tick();
        rst_ni = 1'b1;
        set_alloc(1'b1, 10'd1, USER, 1'b0, 32'h0);
        tick();
        set_alloc(1'b0, '0, INIT, 1'b0, 32'h0);
        check("post_rst_count", 64'(bus.count_o), 64'(1));
        check("post_rst_tag", 64'(bus.alloc_tag_o), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
